hgcal_input_quant_packer: RTL and testbench

//  Front end of the hgcal autoencoder LUT network. Takes one signed sensor sample per beat,

---
 rtl/hgcal_input_quant_packer.sv | 148 ++++++++++++++
 tb/tb_hgcal_input_quant_packer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hgcal_input_quant_packer.sv
// Input front end of the hgcal autoencoder LUT network: quantizes one signed sample per beat to a
// 2-bit code and packs a frame of codes into a double-buffered (pack + output) vector.

module hgcal_quant #(
   parameter int IN_BW = 8,
   parameter int T0    = -16,
   parameter int T1    = 0,
   parameter int T2    = 16
) (
   input  logic [IN_BW-1:0] x,
   output logic [1:0]       code
);
   localparam logic signed [IN_BW-1:0] T0V = IN_BW'(T0);
   localparam logic signed [IN_BW-1:0] T1V = IN_BW'(T1);
   localparam logic signed [IN_BW-1:0] T2V = IN_BW'(T2);

   logic signed [IN_BW-1:0] xs;
   assign xs = x;

   always_comb begin
      code = 2'd3;
      if (xs < T0V)      code = 2'd0;
      else if (xs < T1V) code = 2'd1;
      else if (xs < T2V) code = 2'd2;
   end
endmodule

// One code slot of the pack register; nx is the slot as it would look after this beat's write.
module hgcal_pack_slot #(
   parameter int Q_BW = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wr,
   input  logic            clr,
   input  logic [Q_BW-1:0] d,
   output logic [Q_BW-1:0] q,
   output logic [Q_BW-1:0] nx
);
   assign nx = wr ? d : q;

   always_ff @(posedge clk) begin
      if (!rst)     q <= '0;
      else if (clr) q <= '0;
      else if (wr)  q <= d;
   end
endmodule

module hgcal_input_quant_packer #(
   parameter int NUM_FEATURES = 48,
   parameter int IN_BW        = 8,
   parameter int Q_BW         = 2,
   parameter int T0           = -16,
   parameter int T1           = 0,
   parameter int T2           = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [IN_BW-1:0]             s_data,
   input  logic                         s_last,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [NUM_FEATURES*Q_BW-1:0] m_data,
   output logic                         frame_err
);
   localparam int IW = $clog2(NUM_FEATURES);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_FEATURES - 1);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_PEND} st_t;

   st_t st_q, st_d;
   logic [IW-1:0] idx_q;
   logic [NUM_FEATURES-1:0][Q_BW-1:0] pack_q, pack_nx, out_q;
   logic [NUM_FEATURES-1:0] slot_wr;
   logic [Q_BW-1:0] code;
   logic mv_q, err_q;
   logic xfer, at_end, close, bad, out_free, load_f, load_p, clr;

   hgcal_quant #(.IN_BW(IN_BW), .T0(T0), .T1(T1), .T2(T2)) u_quant (
      .x    (s_data),
      .code (code)
   );

   assign xfer     = s_valid && s_ready;
   assign at_end   = (idx_q == LAST_IDX);
   assign close    = xfer && (s_last || at_end);
   assign bad      = close && !(s_last && at_end);
   assign out_free = !mv_q || m_ready;
   assign load_f   = close && out_free;
   assign load_p   = (st_q == S_PEND) && mv_q && m_ready;
   // Pack is cleared as it leaves, so an early close leaves zeros in the untouched tail.
   assign clr      = load_f || load_p;

   for (genvar i = 0; i < NUM_FEATURES; i++) begin : g_slot
      assign slot_wr[i] = xfer && (idx_q == IW'(i));
      hgcal_pack_slot #(.Q_BW(Q_BW)) u_slot (
         .clk (clk),
         .rst (rst),
         .wr  (slot_wr[i]),
         .clr (clr),
         .d   (code),
         .q   (pack_q[i]),
         .nx  (pack_nx[i])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst) st_q <= S_IDLE;
      else      st_q <= st_d;
   end

   always_comb begin
      st_d = st_q;
      case (st_q)
         S_IDLE:  st_d = S_FILL;
         S_FILL:  if (close && !out_free) st_d = S_PEND;
         S_PEND:  if (load_p) st_d = S_FILL;
         default: st_d = S_IDLE;
      endcase
   end

   always_comb begin
      s_ready = (st_q == S_FILL);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         idx_q <= '0;
         out_q <= '0;
         mv_q  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         if (close)     idx_q <= '0;
         else if (xfer) idx_q <= idx_q + IW'(1);
         if (load_f)      out_q <= pack_nx;
         else if (load_p) out_q <= pack_q;
         if (load_f || load_p) mv_q <= 1'b1;
         else if (m_ready)     mv_q <= 1'b0;
         err_q <= bad;
      end
   end

   assign m_data    = out_q;
   assign m_valid   = mv_q;
   assign frame_err = err_q;
endmodule

// File: tb/tb_hgcal_input_quant_packer.sv
// Bench for hgcal_input_quant_packer: directed sequences plus randomized streams against a
// frame-level reference model (queue of expected vectors).

module tb_hgcal_input_quant_packer;
   localparam int N  = 48;
   localparam int DW = N * 2;

   logic clk = 0, rst = 0;
   logic s_valid = 0, s_last = 0, m_ready = 0;
   logic [7:0] s_data = '0;
   logic s_ready, m_valid, frame_err;
   logic [DW-1:0] m_data;

   hgcal_input_quant_packer dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] x;
      logic [1:0] code;
   } vec_t;

   int errs = 0, checks = 0;
   logic [DW-1:0] expq[$];
   logic [1:0] cur[N];
   int cnt = 0;
   bit exp_err = 0;
   int rdy_mode = 1;
   bit gaps = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] qref(input int x);
      if (x < -16) return 2'd0;
      if (x < 0)   return 2'd1;
      if (x < 16)  return 2'd2;
      return 2'd3;
   endfunction

   function automatic bit rdyv();
      if (rdy_mode == 0) return 1'b0;
      if (rdy_mode == 1) return 1'b1;
      return ($urandom_range(0, 3) != 0);
   endfunction

   // One clock: drive at negedge, update model at posedge, check at next negedge.
   task automatic cyc(input bit v, input logic [7:0] d, input bit l, input bit r, output bit acc);
      bit hs;
      logic [DW-1:0] vec;
      s_valid = v; s_data = d; s_last = l; m_ready = r;
      #1;
      acc = v && s_ready;
      hs  = m_valid && r;
      @(posedge clk);
      exp_err = 0;
      if (hs) begin
         if (expq.size() == 0) chk("spurious_out", 1, 0);
         else void'(expq.pop_front());
      end
      if (acc) begin
         cur[cnt] = qref(int'($signed(d)));
         cnt++;
         if (l || cnt == N) begin
            vec = '0;
            for (int i = 0; i < cnt; i++) vec[2*i +: 2] = cur[i];
            expq.push_back(vec);
            exp_err = !(l && cnt == N);
            cnt = 0;
         end
      end
      @(negedge clk);
      chk("frame_err", frame_err, exp_err);
      chk("m_valid", m_valid, expq.size() > 0);
      chk("s_ready", s_ready, expq.size() < 2);
      if (expq.size() > 0) chk("m_data", m_data, expq[0]);
   endtask

   task automatic send_beat(input logic [7:0] x, input bit l);
      bit acc = 0;
      int n = 0;
      while (!acc && n < 500) begin
         cyc(gaps ? ($urandom_range(0, 3) != 0) : 1'b1, x, l, rdyv(), acc);
         n++;
      end
      if (!acc) chk("send_timeout", 0, 1);
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, rdyv(), acc);
   endtask

   task automatic drain();
      int n = 0;
      rdy_mode = 1;
      while (expq.size() > 0 && n < 20) begin idle(1); n++; end
      chk("drain", expq.size(), 0);
   endtask

   task automatic do_reset(input int n);
      bit acc;
      s_valid = 0; s_last = 0; m_ready = 0; rst = 0;
      expq.delete(); cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); @(negedge clk);
         chk("rst_m_valid", m_valid, 0);
         chk("rst_m_data", m_data, 0);
         chk("rst_s_ready", s_ready, 0);
         chk("rst_frame_err", frame_err, 0);
      end
      rst = 1;
      cyc(1'b0, 8'h00, 1'b0, 1'b1, acc);
      chk("rel_s_ready", s_ready, 1);
   endtask

   task automatic rand_frame(input int len);
      for (int b = 1; b <= len; b++) send_beat(8'($urandom), b == len);
   endtask

   vec_t tbl[12];
   logic [7:0] pat[4];
   logic [DW-1:0] f2;

   initial begin
      tbl[0]  = '{8'hEC, 2'd0};  // -20
      tbl[1]  = '{8'hFF, 2'd1};  // -1
      tbl[2]  = '{8'h00, 2'd2};  // 0
      tbl[3]  = '{8'h14, 2'd3};  // 20
      tbl[4]  = '{8'hF0, 2'd1};  // -16
      tbl[5]  = '{8'hEF, 2'd0};  // -17
      tbl[6]  = '{8'h0F, 2'd2};  // 15
      tbl[7]  = '{8'h10, 2'd3};  // 16
      tbl[8]  = '{8'h80, 2'd0};  // -128
      tbl[9]  = '{8'h7F, 2'd3};  // 127
      tbl[10] = '{8'hF1, 2'd1};  // -15
      tbl[11] = '{8'h01, 2'd2};  // 1
      pat[0] = 8'hEC; pat[1] = 8'hFF; pat[2] = 8'h00; pat[3] = 8'h14;

      @(negedge clk);
      do_reset(3);

      // repeating pattern, normal close
      rdy_mode = 1;
      for (int b = 0; b < N; b++) send_beat(pat[b % 4], b == N - 1);
      chk("t2_low", m_data[7:0], 8'b11100100);
      chk("t2_err", frame_err, 0);
      drain();

      // quantizer thresholds, one frame closed early after the table
      for (int i = 0; i < 12; i++) send_beat(tbl[i].x, i == 11);
      for (int i = 0; i < 12; i++) chk("quant", m_data[2*i +: 2], tbl[i].code);
      chk("t3_tail", m_data[DW-1:24], 0);
      chk("t3_err", frame_err, 1);
      drain();

      // back-pressure: two frames with m_ready low
      rdy_mode = 0;
      rand_frame(N);
      rand_frame(N);
      chk("t4_pend", s_ready, 0);
      f2 = expq[1];
      idle(3);
      begin
         bit acc;
         cyc(1'b0, 8'h00, 1'b0, 1'b1, acc);
      end
      chk("t4_f2", m_data, f2);
      chk("t4_ready", s_ready, 1);
      drain();

      // early close then overlong frame
      rdy_mode = 1;
      rand_frame(10);
      chk("t5_err", frame_err, 1);
      chk("t5_tail", m_data[DW-1:20], 0);
      for (int b = 1; b <= N; b++) send_beat(8'($urandom), 1'b0);
      chk("t5_long_err", frame_err, 1);
      chk("t5_long_vld", m_valid, 1);
      send_beat(8'h14, 1'b0);
      send_beat(8'hEC, 1'b0);
      send_beat(8'h00, 1'b1);
      chk("t5_wrap", m_data[5:0], 6'b100011);
      chk("t5_wrap_tail", m_data[DW-1:6], 0);
      drain();

      // reset mid-frame with output pending, then clean frames
      rdy_mode = 0;
      rand_frame(N);
      for (int b = 1; b < 20; b++) send_beat(8'($urandom), 1'b0);
      do_reset(1);
      rdy_mode = 1;
      rand_frame(N);
      rand_frame(5);
      chk("t6_tail", m_data[DW-1:10], 0);
      drain();

      // randomized stream
      rdy_mode = 2; gaps = 1;
      for (int f = 0; f < 40; f++)
         rand_frame(($urandom_range(0, 2) == 0) ? N : $urandom_range(1, 60));
      gaps = 0;
      drain();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
